// File: rtl/local_bus_arbiter_pkg.sv
// Shared encodings for the local bus arbiter: FSM states, owner codes and
// the owner decode used to drive bus_owner.
package local_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_SLAVE = 2'd1,
        ARB_NCR   = 2'd2,
        ARB_TURN  = 2'd3
    } arb_state_t;

    localparam logic [1:0] OWNER_NONE  = 2'b00;
    localparam logic [1:0] OWNER_SLAVE = 2'b01;
    localparam logic [1:0] OWNER_NCR   = 2'b10;

    localparam int TENURE_CW_MIN = 8;

    function automatic logic [1:0] owner_code(input arb_state_t s);
        case (s)
            ARB_SLAVE: return OWNER_SLAVE;
            ARB_NCR:   return OWNER_NCR;
            default:   return OWNER_NONE;
        endcase
    endfunction

endpackage

// File: rtl/local_bus_arbiter_sync2.sv
// Two-flop synchroniser for a single asynchronous input; the reset value
// lets active-low requests come out of reset deasserted.
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/local_bus_arbiter.sv
// Local bus arbiter between the Zorro slave path and the NCR 53C710 master.
// Define ARB_WATCHDOG_EN to bound NCR tenure at TENURE_MAX cycles.
module local_bus_arbiter
    import local_bus_arbiter_pkg::*;
#(
    parameter int TENURE_MAX  = 255,
    parameter int TURN_CYCLES = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       slave_req,
    input  logic       SBR_n,
    output logic       slave_gnt,
    output logic       SBG_n,
    output logic [1:0] bus_owner,
    output logic       turn_active,
    output logic       arb_timeout
);

    localparam logic [1:0] TURN_LOAD = 2'(TURN_CYCLES - 1);

    logic       w_sbr_n_sync;
    logic       w_ncr_req;
    logic       w_ncr_grantable;
    logic       w_wd_expire;
    arb_state_t r_state;
    arb_state_t w_next_state;
    logic       r_last_ncr;
    logic [1:0] r_turn_cnt;
    logic       r_slave_gnt;
    logic       r_sbg_n;
    logic [1:0] r_bus_owner;
    logic       r_turn_active;

    sync2 #(.RESET_VAL(1'b1)) u_sbr_sync (
        .i_clk   (CLK),
        .i_rst   (RESET),
        .i_async (SBR_n),
        .o_sync  (w_sbr_n_sync)
    );

    assign w_ncr_req = ~w_sbr_n_sync;

`ifdef ARB_WATCHDOG_EN
    localparam int TENURE_CW = ($clog2(TENURE_MAX + 1) > TENURE_CW_MIN) ?
                               $clog2(TENURE_MAX + 1) : TENURE_CW_MIN;
    localparam logic [TENURE_CW-1:0] TENURE_LAST = TENURE_CW'(TENURE_MAX - 1);

    logic [TENURE_CW-1:0] r_tenure;
    logic                 r_ncr_block;
    logic                 r_timeout;

    // Expiry fires on the edge that would complete the TENURE_MAX-th NCR cycle.
    assign w_wd_expire     = (r_state == ARB_NCR) && w_ncr_req && (r_tenure == TENURE_LAST);
    assign w_ncr_grantable = w_ncr_req && !r_ncr_block;
    assign arb_timeout     = r_timeout;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_tenure    <= '0;
            r_ncr_block <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_tenure <= (r_state == ARB_NCR) ? r_tenure + 1'b1 : '0;
            // A revoked NCR must drop its request once before it can win again.
            if (w_wd_expire) begin
                r_timeout   <= 1'b1;
                r_ncr_block <= 1'b1;
            end else if (!w_ncr_req) begin
                r_ncr_block <= 1'b0;
            end
        end
    end
`else
    assign w_wd_expire     = 1'b0;
    assign w_ncr_grantable = w_ncr_req;
    assign arb_timeout     = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (slave_req && w_ncr_grantable)
                    w_next_state = r_last_ncr ? ARB_SLAVE : ARB_NCR;
                else if (slave_req)
                    w_next_state = ARB_SLAVE;
                else if (w_ncr_grantable)
                    w_next_state = ARB_NCR;
            end
            ARB_SLAVE: if (!slave_req) w_next_state = ARB_TURN;
            ARB_NCR:   if (!w_ncr_req || w_wd_expire) w_next_state = ARB_TURN;
            ARB_TURN:  if (r_turn_cnt == 2'd0) w_next_state = ARB_IDLE;
            default:   w_next_state = ARB_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change with the state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= ARB_IDLE;
            r_last_ncr    <= 1'b1;
            r_turn_cnt    <= 2'd0;
            r_slave_gnt   <= 1'b0;
            r_sbg_n       <= 1'b1;
            r_bus_owner   <= OWNER_NONE;
            r_turn_active <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state == ARB_SLAVE && r_state != ARB_SLAVE) r_last_ncr <= 1'b0;
            if (w_next_state == ARB_NCR && r_state != ARB_NCR)     r_last_ncr <= 1'b1;
            if (w_next_state == ARB_TURN && r_state != ARB_TURN)
                r_turn_cnt <= TURN_LOAD;
            else if (r_state == ARB_TURN && r_turn_cnt != 2'd0)
                r_turn_cnt <= r_turn_cnt - 2'd1;
            r_slave_gnt   <= (w_next_state == ARB_SLAVE);
            r_sbg_n       <= (w_next_state != ARB_NCR);
            r_bus_owner   <= owner_code(w_next_state);
            r_turn_active <= (w_next_state == ARB_TURN);
        end
    end

    assign slave_gnt   = r_slave_gnt;
    assign SBG_n       = r_sbg_n;
    assign bus_owner   = r_bus_owner;
    assign turn_active = r_turn_active;

endmodule

// File: tb/tb_local_bus_arbiter.sv
// Self-checking bench for local_bus_arbiter: directed latency scenarios plus a
// randomised run against a cycle-level reference model of the arbitration rules.
module tb_local_bus_arbiter;

  localparam int TENURE = 16;
  localparam int TURN   = 1;
`ifdef ARB_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       slave_req = 1'b0;
  logic       SBR_n = 1'b1;
  logic       slave_gnt;
  logic       SBG_n;
  logic [1:0] bus_owner;
  logic       turn_active;
  logic       arb_timeout;

  int n_checks = 0;
  int n_fail = 0;

  local_bus_arbiter #(.TENURE_MAX(TENURE), .TURN_CYCLES(TURN)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .slave_req   (slave_req),
    .SBR_n       (SBR_n),
    .slave_gnt   (slave_gnt),
    .SBG_n       (SBG_n),
    .bus_owner   (bus_owner),
    .turn_active (turn_active),
    .arb_timeout (arb_timeout)
  );

  // ---------------- clock / time limit ----------------
  always #20 CLK = ~CLK;

  initial begin
    #5ms;
    $display("FAIL time_limit: simulation did not finish, got running, need finished");
    $fatal(1, "time limit");
  end

  // ---------------- reference model ----------------
  // Owner: 0 none, 1 slave, 2 NCR. The NCR request reaches the arbiter two
  // edges after it is sampled; turnaround is a countdown of dead cycles.
  int m_owner;
  int m_turn_left;
  int m_tenure;
  bit m_last_ncr;
  bit m_timeout;
  bit m_blocked;
  bit m_hist[2];
  bit m_ncr;
  bit m_want_ncr;

  always @(posedge CLK) begin
    if (RESET) begin
      m_owner = 0; m_turn_left = 0; m_tenure = 0;
      m_last_ncr = 1; m_timeout = 0; m_blocked = 0;
      m_hist[0] = 1; m_hist[1] = 1;
    end else begin
      m_ncr = !m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = SBR_n;
      if (m_turn_left > 0) begin
        m_turn_left--;
      end else if (m_owner == 1) begin
        if (!slave_req) begin m_owner = 0; m_turn_left = TURN; end
      end else if (m_owner == 2) begin
        m_tenure++;
        if (!m_ncr) begin
          m_owner = 0; m_turn_left = TURN;
        end else if (WD_EN && m_tenure == TENURE) begin
          m_owner = 0; m_turn_left = TURN; m_timeout = 1; m_blocked = 1;
        end
      end else begin
        m_want_ncr = m_ncr && !m_blocked;
        if (slave_req && (!m_want_ncr || m_last_ncr)) begin
          m_owner = 1; m_last_ncr = 0;
        end else if (m_want_ncr) begin
          m_owner = 2; m_last_ncr = 1; m_tenure = 0;
        end
      end
      if (!m_ncr) m_blocked = 0;
    end
  end

  function automatic logic [5:0] exp_vec();
    logic [1:0] oc;
    oc = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
    return {m_owner == 1, m_owner != 2, oc, m_turn_left > 0, m_timeout};
  endfunction

  function automatic logic [5:0] obs_vec();
    return {slave_gnt, SBG_n, bus_owner, turn_active, arb_timeout};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1; slave_req = 1'b0; SBR_n = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RESET = 1'b1; slave_req = 1'b1; SBR_n = 1'b0;
    repeat (2) @(negedge CLK);
    n_checks++;
    if (obs_vec() !== 6'b010000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, need %b", obs_vec(), 6'b010000);
    end
    slave_req = 1'b0; SBR_n = 1'b1; RESET = 1'b0;
    repeat (3) @(negedge CLK);
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_idle: got %b, need %b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_slave_only();
    do_reset();
    for (int c = 0; c <= 7; c++) begin
      @(negedge CLK);
      if (c == 0 || c == 6) begin
        n_checks++;
        if (slave_gnt !== 1'b0) begin
          n_fail++;
          $display("FAIL slave_gnt_low c=%0d: got %b, need 0", c, slave_gnt);
        end
      end
      if (c >= 1 && c <= 5) begin
        n_checks++;
        if ({slave_gnt, bus_owner} !== 3'b101) begin
          n_fail++;
          $display("FAIL slave_grant c=%0d: got %b, need 101", c, {slave_gnt, bus_owner});
        end
      end
      if (c == 6) begin
        n_checks++;
        if ({turn_active, bus_owner} !== 3'b100) begin
          n_fail++;
          $display("FAIL slave_turn c=%0d: got %b, need 100", c, {turn_active, bus_owner});
        end
      end
      if (c == 7) begin
        n_checks++;
        if ({turn_active, bus_owner, slave_gnt} !== 4'b0000) begin
          n_fail++;
          $display("FAIL slave_idle c=%0d: got %b, need 0000", c, {turn_active, bus_owner, slave_gnt});
        end
      end
      slave_req = (c < 5);
    end
  endtask

  task automatic test_ncr_only();
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      @(negedge CLK);
      if (c >= 3 && c <= 10) begin
        n_checks++;
        if ({SBG_n, bus_owner} !== 3'b010) begin
          n_fail++;
          $display("FAIL ncr_grant c=%0d: got %b, need 010", c, {SBG_n, bus_owner});
        end
      end else begin
        n_checks++;
        if (SBG_n !== 1'b1) begin
          n_fail++;
          $display("FAIL ncr_no_grant c=%0d: got %b, need 1", c, SBG_n);
        end
      end
      if (c == 11) begin
        n_checks++;
        if (turn_active !== 1'b1) begin
          n_fail++;
          $display("FAIL ncr_turn c=%0d: got %b, need 1", c, turn_active);
        end
      end
      SBR_n = !(c < 8);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      @(negedge CLK);
      if (c >= 1 && c <= 4) begin
        n_checks++;
        if ({slave_gnt, SBG_n} !== 2'b11) begin
          n_fail++;
          $display("FAIL simul_slave_first c=%0d: got %b, need 11", c, {slave_gnt, SBG_n});
        end
      end
      if (c == 5) begin
        n_checks++;
        if ({turn_active, slave_gnt, SBG_n} !== 3'b101) begin
          n_fail++;
          $display("FAIL simul_turn c=%0d: got %b, need 101", c, {turn_active, slave_gnt, SBG_n});
        end
      end
      if (c == 7) begin
        n_checks++;
        if ({slave_gnt, SBG_n, bus_owner} !== 4'b0010) begin
          n_fail++;
          $display("FAIL simul_ncr_next c=%0d: got %b, need 0010", c, {slave_gnt, SBG_n, bus_owner});
        end
      end
      slave_req = (c < 4);
      SBR_n = !(c < 7);
    end
  endtask

  task automatic test_reset_mid_tenure();
    int waited;
    do_reset();
    SBR_n = 1'b0;
    waited = 0;
    while (SBG_n !== 1'b0 && waited < 8) begin
      @(negedge CLK);
      waited++;
    end
    n_checks++;
    if (SBG_n !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_tenure_grant: got SBG_n=%b after %0d cycles, need 0", SBG_n, waited);
    end
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (obs_vec() !== 6'b010000) begin
      n_fail++;
      $display("FAIL reset_drops_grant: got %b, need %b", obs_vec(), 6'b010000);
    end
    RESET = 1'b0;
    repeat (5) @(negedge CLK);
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL post_reset_regrant: got %b, need %b", obs_vec(), exp_vec());
    end
    SBR_n = 1'b1;
    repeat (6) @(negedge CLK);
  endtask

`ifdef ARB_WATCHDOG_EN
  task automatic test_watchdog();
    int waited;
    int low_cycles;
    int regrants;
    do_reset();
    SBR_n = 1'b0;
    waited = 0;
    while (SBG_n !== 1'b0 && waited < 8) begin
      @(negedge CLK);
      waited++;
    end
    low_cycles = 0;
    while (SBG_n === 1'b0 && low_cycles < 4 * TENURE) begin
      low_cycles++;
      @(negedge CLK);
    end
    n_checks++;
    if (low_cycles != TENURE) begin
      n_fail++;
      $display("FAIL wd_tenure_len: got %0d cycles, need %0d", low_cycles, TENURE);
    end
    n_checks++;
    if (arb_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_timeout_flag: got %b, need 1", arb_timeout);
    end
    regrants = 0;
    repeat (20) begin
      @(negedge CLK);
      if (SBG_n === 1'b0) regrants++;
    end
    n_checks++;
    if (regrants != 0) begin
      n_fail++;
      $display("FAIL wd_no_regrant: got %0d grant cycles, need 0", regrants);
    end
    SBR_n = 1'b1;
    repeat (4) @(negedge CLK);
    SBR_n = 1'b0;
    waited = 0;
    while (SBG_n !== 1'b0 && waited < 8) begin
      @(negedge CLK);
      waited++;
    end
    n_checks++;
    if ({SBG_n, arb_timeout} !== 2'b01) begin
      n_fail++;
      $display("FAIL wd_regrant_after_toggle: got %b, need 01", {SBG_n, arb_timeout});
    end
    SBR_n = 1'b1;
    repeat (6) @(negedge CLK);
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL rand_model cyc=%0d: got %b, need %b", i, obs_vec(), exp_vec());
      end
      n_checks++;
      if (slave_gnt === 1'b1 && SBG_n === 1'b0) begin
        n_fail++;
        $display("FAIL mutual_exclusion cyc=%0d: got both grants, need at most one", i);
      end
      if ($urandom_range(0, 5) == 0) slave_req = ~slave_req;
      if ($urandom_range(0, 7) == 0) SBR_n = ~SBR_n;
      RESET = ($urandom_range(0, 299) == 0);
    end
    RESET = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_slave_only();
    test_ncr_only();
    test_simultaneous();
    test_reset_mid_tenure();
`ifdef ARB_WATCHDOG_EN
    test_watchdog();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/local_bus_arbiter.md
LOCAL_BUS_ARBITER -- requirements
Module: local_bus_arbiter

Interface
REQ-001 SHALL have parameter TENURE_MAX, default 255: maximum NCR bus-tenure cycles before watchdog revoke.
REQ-002 SHALL have parameter TURN_CYCLES, default 1: dead cycles between owners (range 1..3).
REQ-003 SHALL have port CLK, input, 1: 25 MHz card clock; one clock, all logic on rising edge.
REQ-004 SHALL have port RESET, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port slave_req, input, 1: Zorro slave access needs the local bus (level, synchronous to CLK).
REQ-006 SHALL have port SBR_n, input, 1: NCR 53C710 bus request, asynchronous, active-low.
REQ-007 SHALL have port slave_gnt, output, 1: local bus granted to the Zorro slave path.
REQ-008 SHALL have port SBG_n, output, 1: local bus grant to the NCR, active-low.
REQ-009 SHALL have port bus_owner, output, 2: current owner code NONE/SLAVE/NCR.
REQ-010 SHALL have port turn_active, output, 1: high during turnaround dead cycles.
REQ-011 SHALL have port arb_timeout, output, 1: sticky NCR tenure-overrun flag.

Function
REQ-012 SHALL synchronise SBR_n through two flops; ncr_req is the inverted second flop.
REQ-013 SHALL implement states ARB_IDLE, ARB_SLAVE, ARB_NCR, ARB_TURN.
REQ-014 In ARB_IDLE with one request, SHALL go to the matching owner state on the next edge.
REQ-015 In ARB_IDLE with both requests, SHALL grant the requester not served last (round-robin bit last_ncr).
REQ-016 SHALL update last_ncr on entry to ARB_SLAVE (0) or ARB_NCR (1).
REQ-017 slave_gnt SHALL be high exactly while in ARB_SLAVE; SBG_n SHALL be low exactly while in ARB_NCR.
REQ-018 Outputs SHALL be registered; latency slave_req rise to slave_gnt = 1 cycle; SBR_n fall to SBG_n low = 3 cycles.
REQ-019 ARB_SLAVE SHALL hold until slave_req low, then enter ARB_TURN; ARB_NCR SHALL hold until ncr_req low, then enter ARB_TURN.
REQ-020 ARB_TURN SHALL last exactly TURN_CYCLES cycles with no grant, then enter ARB_IDLE.
REQ-021 A request arriving during ARB_TURN SHALL be evaluated in ARB_IDLE; no grant is issued directly from ARB_TURN.
REQ-022 The grant SHALL never be revoked by a competing request; only release or watchdog ends a tenure.
REQ-023 bus_owner SHALL be 2'b00 in IDLE/TURN, 2'b01 in SLAVE, 2'b10 in NCR.
REQ-024 slave_gnt and SBG_n low SHALL never be active in the same cycle.

Reset
REQ-025 On RESET high at an edge: state ARB_IDLE, slave_gnt 0, SBG_n 1, bus_owner 0, turn_active 0, arb_timeout 0, sync flops 1, last_ncr 1, tenure counter 0.
REQ-026 RESET asserted mid-tenure SHALL drop every grant on that same edge, with no turnaround.

Configuration
REQ-027 With ARB_WATCHDOG_EN defined: an 8-bit-or-wider tenure counter SHALL clear on ARB_NCR entry and increment each ARB_NCR cycle.
REQ-028 With ARB_WATCHDOG_EN defined: when the counter reaches TENURE_MAX, SHALL set arb_timeout, deassert SBG_n, and enter ARB_TURN.
REQ-029 With ARB_WATCHDOG_EN defined: arb_timeout SHALL clear only on RESET.
REQ-030 With ARB_WATCHDOG_EN defined: after a revoke, SHALL not re-grant the NCR until ncr_req has been seen low at least once.
REQ-031 Without ARB_WATCHDOG_EN: no counter; arb_timeout tied 0; NCR tenure unbounded.

Structure
REQ-032 State encodings (ARB_IDLE..ARB_TURN) and owner codes SHALL live in the shared globalparams.vh alongside the Z3_* states.
REQ-033 The two-flop synchroniser SHALL be a sub-module named sync2, reusable for other asynchronous inputs.

Verification
REQ-034 Slave only: slave_req high at cycle 0 -> slave_gnt high at cycle 1; slave_req low at cycle 5 -> turn_active high at cycle 6, IDLE at cycle 7.
REQ-035 NCR only: SBR_n low at cycle 0 -> SBG_n low at cycle 3, bus_owner=2'b10; SBR_n high -> SBG_n high 3 cycles later.
REQ-036 Simultaneous requests after reset -> slave granted first; after release and turnaround -> NCR granted.
REQ-037 Watchdog build, TENURE_MAX=16, SBR_n held low -> SBG_n high after 16 NCR cycles, arb_timeout=1, no re-grant until SBR_n toggles high.
REQ-038 RESET pulsed during NCR tenure -> SBG_n=1 and bus_owner=0 on the reset edge; mutual exclusion assertion holds throughout a randomised run.
